// File: rtl/retire_trace_pkg.sv
// retire_trace_pkg: kind codes, header layout, per-kind word counts and serializer states.
// RETIRE_TRACE_CYCLE_STAMP_EN adds the per-record CYCLE word, its storage and state S_CYC.
package retire_trace_pkg;
  typedef enum logic [3:0] {
    K_NOP = 4'd0, K_REG = 4'd1, K_LD = 4'd2, K_ST = 4'd3, K_STU = 4'd4, K_HALT = 4'd5
  } kind_e;
  localparam int HDR_KIND_LSB = 12;
  localparam int HDR_WREG_LSB = 9;
  localparam int HDR_OVF_BIT = 8;
  localparam logic [1:0] WORDS_NOP = 2'd0;
  localparam logic [1:0] WORDS_REG = 2'd1;
  localparam logic [1:0] WORDS_LD = 2'd2;
  localparam logic [1:0] WORDS_ST = 2'd2;
  localparam logic [1:0] WORDS_STU = 2'd3;
  localparam logic [1:0] WORDS_HALT = 2'd2;
  // word-emitting states are consecutive so the serializer can advance by increment
  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_INUM,
`ifdef RETIRE_TRACE_CYCLE_STAMP_EN
    S_CYC,
`endif
    S_PC, S_F1, S_F2, S_F3, S_DONE
  } state_e;
  typedef struct packed {
    logic [15:0] hdr;
    logic [15:0] inum;
`ifdef RETIRE_TRACE_CYCLE_STAMP_EN
    logic [15:0] cyc;
`endif
    logic [15:0] pc, f1, f2, f3;
  } rec_t;
  function automatic logic [1:0] field_words(kind_e k);
    return k == K_STU ? WORDS_STU : k == K_LD ? WORDS_LD : k == K_ST ? WORDS_ST :
           k == K_HALT ? WORDS_HALT : k == K_REG ? WORDS_REG : WORDS_NOP;
  endfunction
  function automatic logic [15:0] make_hdr(kind_e k, logic [2:0] wreg, logic ovf);
    logic [15:0] h;
    h = '0;
    h[HDR_KIND_LSB +: 4] = k;
    h[HDR_WREG_LSB +: 3] = wreg;
    h[HDR_OVF_BIT] = ovf;
    return h;
  endfunction
endpackage

// File: rtl/retire_trace_tx_fifo.sv
// trace_rec_fifo: power-of-two record FIFO; a pop at full frees the slot for a same-cycle push.
module trace_rec_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    dout = mem_q[rd_q];
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/retire_trace_tx.sv
// retire_trace_tx: captures retired instructions as records and streams them as 16-bit trace words.
// Define RETIRE_TRACE_CYCLE_STAMP_EN to add a capture-cycle word between INUM and PC in every record.
module retire_trace_tx
  import retire_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [15:0] pc,
  input  logic        reg_write,
  input  logic [2:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        overflow,
  output logic        done
);
  kind_e kind, head_kind;
  rec_t rec, head, side_q, side_d;
  logic side_valid_q, side_valid_d, halted_q, halted_d, overflow_q, overflow_d;
  logic [15:0] inst_q, inst_d, cyc_q, cyc_d;
  state_e state_q, state_d;
  logic accept, space, full, empty, push, pop, xfer;
  logic [1:0] nw;
  always_comb begin
    kind = reg_write && mem_write ? K_STU : reg_write && mem_read ? K_LD : reg_write ? K_REG :
           halt ? K_HALT : mem_write ? K_ST : K_NOP;
    accept = commit_valid && !halted_q;
    rec.hdr = make_hdr(kind, reg_write ? write_reg : 3'd0, overflow_q);
    rec.inum = inst_q;
`ifdef RETIRE_TRACE_CYCLE_STAMP_EN
    rec.cyc = cyc_q;
`endif
    rec.pc = pc;
    rec.f1 = kind == K_ST ? mem_addr : kind == K_HALT ? cyc_q : write_data;
    rec.f2 = kind == K_ST ? mem_data : kind == K_HALT ? inst_q + 16'd1 : mem_addr;
    rec.f3 = mem_data;
    space = !full || pop;
    // a parked HALT owns the push port; no commit can compete once halted
    push = side_valid_q || accept;
    side_valid_d = side_valid_q ? !space : accept && kind == K_HALT && !space;
    side_d = side_valid_q ? side_q : rec;
    overflow_d = overflow_q || (accept && kind != K_HALT && !space);
    halted_d = halted_q || (accept && kind == K_HALT);
    inst_d = inst_q + {15'd0, accept};
    cyc_d = cyc_q + 16'd1;
  end
  trace_rec_fifo #(.DEPTH(DEPTH), .W($bits(rec_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(side_valid_q ? side_q : rec),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    head_kind = kind_e'(head.hdr[HDR_KIND_LSB +: 4]);
    nw = field_words(head_kind);
    out_valid = state_q != S_IDLE && state_q != S_DONE;
    out_last = (state_q == S_PC && nw == 2'd0) || (state_q == S_F1 && nw == 2'd1) ||
               (state_q == S_F2 && nw == 2'd2) || state_q == S_F3;
    case (state_q)
      S_HDR:   out_data = head.hdr;
      S_INUM:  out_data = head.inum;
`ifdef RETIRE_TRACE_CYCLE_STAMP_EN
      S_CYC:   out_data = head.cyc;
`endif
      S_PC:    out_data = head.pc;
      S_F1:    out_data = head.f1;
      S_F2:    out_data = head.f2;
      S_F3:    out_data = head.f3;
      default: out_data = 16'd0;
    endcase
    xfer = out_valid && out_ready;
    // the record stays at the FIFO head until its last word leaves, keeping words stable
    pop = xfer && out_last;
    overflow = overflow_q;
    done = state_q == S_DONE;
    state_d = state_q;
    if (state_q == S_IDLE && !empty) state_d = S_HDR;
    else if (xfer) state_d = out_last ? (head_kind == K_HALT ? S_DONE : S_IDLE) : state_e'(state_q + 4'd1);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      side_q <= '0;
      side_valid_q <= 1'b0;
      halted_q <= 1'b0;
      overflow_q <= 1'b0;
      inst_q <= '0;
      cyc_q <= '0;
    end else begin
      state_q <= state_d;
      side_q <= side_d;
      side_valid_q <= side_valid_d;
      halted_q <= halted_d;
      overflow_q <= overflow_d;
      inst_q <= inst_d;
      cyc_q <= cyc_d;
    end
  end
endmodule

// File: tb/tb_retire_trace_tx.sv
// tb_retire_trace_tx: directed checks of the retire trace stream with hand-computed words.
module tb_retire_trace_tx;
  logic clk = 0, rst = 0, commit_valid = 0, reg_write = 0, mem_read = 0, mem_write = 0, halt = 0, out_ready = 0;
  logic [15:0] pc = 0, write_data = 0, mem_addr = 0, mem_data = 0;
  logic [2:0] write_reg = 0;
  logic out_valid, out_last, overflow, done;
  logic [15:0] out_data;
  logic [16:0] wq [$];
  int compares = 0, fails = 0;
  always #5 clk = ~clk;
  retire_trace_tx #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .pc(pc), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data(mem_data), .halt(halt), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .overflow(overflow), .done(done)
  );
  // transfers are logged mid-cycle; each one completes on the following rising edge
  always @(negedge clk) if (rst && out_valid && out_ready) wq.push_back({out_last, out_data});
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    commit_valid = 0; reg_write = 0; mem_read = 0; mem_write = 0; halt = 0; out_ready = 0;
    rst = 0;
    repeat (2) step;
    wq.delete();
    rst = 1;
  endtask
  task automatic do_commit(input logic [15:0] p, input logic rw, input logic [2:0] wr, input logic [15:0] wd,
                           input logic mr, input logic mw, input logic [15:0] ma, input logic [15:0] md,
                           input logic h);
    commit_valid = 1; pc = p; reg_write = rw; write_reg = wr; write_data = wd;
    mem_read = mr; mem_write = mw; mem_addr = ma; mem_data = md; halt = h;
    step;
    commit_valid = 0; reg_write = 0; mem_read = 0; mem_write = 0; halt = 0;
  endtask
  task automatic wait_words(input int n);
    int t = 0;
    while (wq.size() < n && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    compares++;
    if (wq.size() < n) begin
      fails++;
      $display("FAIL wait_words got %0d words need %0d", wq.size(), n);
    end
  endtask
  task automatic test_reset;
    do_reset;
    compares += 5;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
    if (out_last !== 1'b0) begin fails++; $display("FAIL reset_last got %b want 0", out_last); end
    if (out_data !== 16'h0000) begin fails++; $display("FAIL reset_data got %h want 0000", out_data); end
    if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
  endtask
  task automatic test_reg;
    logic [16:0] exp [4];
    exp = '{17'h01600, 17'h00000, 17'h00002, 17'h11234};
    do_reset;
    out_ready = 1;
    do_commit(16'h0002, 1, 3'd3, 16'h1234, 0, 0, 16'h0, 16'h0, 0);
    wait_words(4);
    for (int i = 0; i < 4; i++) begin
      compares++;
      if (wq[i] !== exp[i]) begin fails++; $display("FAIL reg_word[%0d] got %h want %h", i, wq[i], exp[i]); end
    end
  endtask
  task automatic test_back_to_back;
    logic [16:0] exp [10];
    exp = '{17'h03000, 17'h00000, 17'h00010, 17'h00100, 17'h1beef,
            17'h02a00, 17'h00001, 17'h00012, 17'h05555, 17'h10200};
    do_reset;
    do_commit(16'h0010, 0, 3'd0, 16'h0, 0, 1, 16'h0100, 16'hbeef, 0);
    do_commit(16'h0012, 1, 3'd5, 16'h5555, 1, 0, 16'h0200, 16'h0, 0);
    for (int i = 0; i < 10; i++) begin
      compares++;
      if (out_valid !== 1'b1 || out_data !== 16'h3000 || out_last !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d] valid=%b data=%h last=%b want 1/3000/0", i, out_valid, out_data, out_last);
      end
      step;
    end
    out_ready = 1;
    wait_words(10);
    for (int i = 0; i < 10; i++) begin
      compares++;
      if (wq[i] !== exp[i]) begin fails++; $display("FAIL b2b_word[%0d] got %h want %h", i, wq[i], exp[i]); end
    end
  endtask
  task automatic test_overflow;
    logic [16:0] exp;
    do_reset;
    for (int i = 0; i < 6; i++) do_commit(16'h0020 + 16'(i), 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    compares++;
    if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow); end
    out_ready = 1;
    wait_words(12);
    do_commit(16'h0030, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    wait_words(15);
    for (int i = 0; i < 15; i++) begin
      exp = i >= 12 ? (i == 12 ? 17'h00100 : i == 13 ? 17'h00006 : 17'h10030) :
            i % 3 == 0 ? 17'h00000 : i % 3 == 1 ? 17'(i / 3) : 17'h10020 + 17'(i / 3);
      compares++;
      if (wq[i] !== exp) begin fails++; $display("FAIL ovf_word[%0d] got %h want %h", i, wq[i], exp); end
    end
    compares++;
    if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask
  task automatic test_halt;
    logic [16:0] exp [5];
    exp = '{17'h05000, 17'h00004, 17'h00050, 17'h00014, 17'h10005};
    do_reset;
    for (int i = 0; i < 20; i++) begin
      commit_valid = i < 4;
      pc = 16'h0040 + 16'(i);
      step;
    end
    do_commit(16'h0050, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    compares++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL halt_no_drop overflow got %b want 0", overflow); end
    out_ready = 1;
    wait_words(17);
    for (int i = 0; i < 5; i++) begin
      compares++;
      if (wq[12 + i] !== exp[i]) begin fails++; $display("FAIL halt_word[%0d] got %h want %h", i, wq[12 + i], exp[i]); end
    end
    compares++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_early got %b want 0", done); end
    step;
    compares++;
    if (done !== 1'b1) begin fails++; $display("FAIL done_rise got %b want 1", done); end
    do_commit(16'h0060, 1, 3'd1, 16'h7777, 0, 0, 16'h0, 16'h0, 0);
    do_commit(16'h0062, 0, 3'd0, 16'h0, 0, 1, 16'h0010, 16'h0011, 0);
    repeat (3) step;
    compares++;
    if (out_valid !== 1'b0 || done !== 1'b1 || overflow !== 1'b0 || wq.size() != 17) begin
      fails++;
      $display("FAIL halt_ignore valid=%b done=%b ovf=%b words=%0d want 0/1/0/17", out_valid, done, overflow, wq.size());
    end
  endtask
  task automatic test_reset_mid;
    logic [16:0] exp [4];
    exp = '{17'h04400, 17'h00000, 17'h00060, 17'h0};
    do_reset;
    out_ready = 1;
    do_commit(16'h0060, 1, 3'd2, 16'h1111, 0, 1, 16'h0300, 16'h2222, 0);
    wait_words(3);
    for (int i = 0; i < 3; i++) begin
      compares++;
      if (wq[i] !== exp[i]) begin fails++; $display("FAIL stu_word[%0d] got %h want %h", i, wq[i], exp[i]); end
    end
    step;
    compares++;
    if (out_valid !== 1'b1 || out_data !== 16'h1111) begin
      fails++;
      $display("FAIL stu_value valid=%b data=%h want 1/1111", out_valid, out_data);
    end
    rst = 0;
    step;
    compares++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
    wq.delete();
    rst = 1;
    do_commit(16'h0070, 1, 3'd1, 16'habcd, 0, 0, 16'h0, 16'h0, 0);
    wait_words(4);
    exp = '{17'h01200, 17'h00000, 17'h00070, 17'h1abcd};
    for (int i = 0; i < 4; i++) begin
      compares++;
      if (wq[i] !== exp[i]) begin fails++; $display("FAIL restart_word[%0d] got %h want %h", i, wq[i], exp[i]); end
    end
  endtask
  initial begin
    test_reset;
    test_reg;
    test_back_to_back;
    test_overflow;
    test_halt;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
